tri_bus_arbiter: RTL and testbench

//   Round-robin arbiter for one shared tri-state bus driven by N it/nit/ite/nite buffer stages.

---
 rtl/tri_bus_arbiter.sv | 137 +++++++++++++
 tb/tb_tri_bus_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/tri_bus_arbiter.sv
// ============================================================================
// Module   : tri_bus_arbiter
// Purpose  : Round-robin owner arbiter for a shared tri-state bus. It drives a
//            registered one-hot grant with matching active-low buffer enables,
//            and leaves TA_CYC dead cycles after every release.
// Options  : TRI_ARB_TIMEOUT_EN limits each grant to MAX_HOLD cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tri_bus_arbiter #(
    parameter int N        = 4,
    parameter int IDW      = 2,
    parameter int MAX_HOLD = 8,
    parameter int TA_CYC   = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   oe_n,
    output logic           busy,
    output logic [IDW-1:0] owner
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

`ifdef TRI_ARB_TIMEOUT_EN
    localparam logic c_timeout_en = 1'b1;
`else
    localparam logic c_timeout_en = 1'b0;
`endif
    localparam logic [7:0]     c_hold_last = 8'(MAX_HOLD - 1);
    localparam logic [3:0]     c_ta_last   = 4'(TA_CYC - 1);
    localparam logic [N-1:0]   c_one       = {{(N-1){1'b0}}, 1'b1};
    localparam logic [IDW-1:0] c_ptr_rst   = IDW'(N - 1);

    state_t         r_state, w_state_nxt;
    logic [N-1:0]   r_gnt, w_gnt_nxt;
    logic [N-1:0]   r_oe_n;
    logic [IDW-1:0] r_owner, w_owner_nxt;
    logic [IDW-1:0] r_ptr, w_ptr_nxt;
    logic [7:0]     r_hold, w_hold_nxt;
    logic [3:0]     r_ta, w_ta_nxt;

    logic           w_found;
    logic [IDW-1:0] w_win;
    logic [IDW-1:0] w_cand;
    logic           w_release;

    // Rotating search: the candidate right after the last winner goes first.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int i = 1; i <= N; i++) begin
            w_cand = IDW'((int'(r_ptr) + i) % N);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    // Timeout and owner-drop coincide into one release.
    assign w_release = !req[r_owner] || (c_timeout_en && (r_hold == c_hold_last));

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold;
        w_ta_nxt    = r_ta;
        case (r_state)
            ST_GRANT: begin
                if (w_release) begin
                    w_gnt_nxt   = '0;
                    w_ta_nxt    = '0;
                    w_state_nxt = ST_TURN;
                end else if (r_hold != 8'hFF) begin
                    w_hold_nxt = r_hold + 8'd1;
                end
            end
            ST_IDLE, ST_TURN: begin
                if (r_state == ST_TURN && r_ta != c_ta_last) begin
                    w_ta_nxt = r_ta + 4'd1;
                end else if (w_found) begin
                    w_gnt_nxt   = c_one << w_win;
                    w_owner_nxt = w_win;
                    w_ptr_nxt   = w_win;
                    w_hold_nxt  = '0;
                    w_state_nxt = ST_GRANT;
                end else begin
                    w_gnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_oe_n  <= '1;
            r_owner <= '0;
            r_ptr   <= c_ptr_rst;
            r_hold  <= '0;
            r_ta    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_oe_n  <= ~w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= w_hold_nxt;
            r_ta    <= w_ta_nxt;
        end
    end

    assign gnt   = r_gnt;
    assign oe_n  = r_oe_n;
    assign busy  = (r_state != ST_IDLE);
    assign owner = r_owner;

endmodule

`default_nettype wire

// File: tb/tb_tri_bus_arbiter.sv
// ============================================================================
// Module   : tb_tri_bus_arbiter
// Purpose  : Scoreboard bench for tri_bus_arbiter with a queue-based reference
//            model of round-robin ownership and turnaround gaps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tri_bus_arbiter;

    localparam int N        = 4;
    localparam int IDW      = 2;
    localparam int MAX_HOLD = 8;
    localparam int TA_CYC   = 1;
`ifdef TRI_ARB_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif

    typedef struct {
        logic [N-1:0]   gnt;
        logic           busy;
        logic [IDW-1:0] owner;
    } exp_t;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [N-1:0]   oe_n;
    logic           busy;
    logic [IDW-1:0] owner;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: who owns the bus, who won last, dead cycles left.
    int m_owner, m_last, m_dead, m_len, m_out_owner;
    bit m_busy;

    tri_bus_arbiter #(
        .N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD), .TA_CYC(TA_CYC)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .oe_n(oe_n), .busy(busy), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1; m_last = N - 1; m_dead = 0; m_len = 0;
        m_out_owner = 0; m_busy = 1'b0;
    endfunction

    function automatic void model_arb(input logic [N-1:0] r);
        m_busy = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int c = (m_last + k) % N;
            if (r[c]) begin
                m_owner = c; m_last = c; m_len = 0;
                m_out_owner = c; m_busy = 1'b1;
                return;
            end
        end
    endfunction

    function automatic void model_step(input logic [N-1:0] r);
        if (m_owner >= 0) begin
            m_len++;
            if (!r[m_owner] || (TO && m_len >= MAX_HOLD)) begin
                m_owner = -1; m_dead = TA_CYC; m_busy = 1'b1;
            end
        end else if (m_dead > 0) begin
            m_dead--;
            if (m_dead == 0) model_arb(r);
        end else begin
            model_arb(r);
        end
    endfunction

    task automatic drive(input logic [N-1:0] v);
        exp_t e;
        req = v;
        model_step(v);
        e.gnt = '0;
        if (m_owner >= 0) e.gnt[m_owner] = 1'b1;
        e.busy  = m_busy;
        e.owner = IDW'(m_out_owner);
        q.push_back(e);
    endtask

    task automatic cycle(input logic [N-1:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(v);
        end
    endtask

    task automatic check_reset_outputs();
        logic [N-1:0] ones;
        ones = '1;
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_oe_n", int'(oe_n), int'(ones));
        chk("rst_busy", int'(busy), 0);
        chk("rst_owner", int'(owner), 0);
    endtask

    // Asynchronous reset applied between edges; outputs must clear at once.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive('0);
    endtask

    // Monitor: scoreboard pops plus bus-safety invariants every cycle.
    initial begin : monitor
        exp_t         e;
        logic [N-1:0] prev_gnt;
        logic [N-1:0] inv;
        int           zeros;
        bit           had_grant;
        prev_gnt = '0; zeros = 0; had_grant = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            inv = ~gnt;
            chk("onehot0", int'($onehot0(gnt)), 1);
            chk("oe_n_inv", int'(oe_n), int'(inv));
            if (gnt == '0) begin
                zeros++;
            end else if (prev_gnt == '0) begin
                if (had_grant) chk("ta_gap_ok", int'(zeros >= TA_CYC), 1);
                chk("gnt_has_req", int'((gnt & req) != '0), 1);
                had_grant = 1'b1;
                zeros = 0;
            end
            prev_gnt = gnt;
            if (q.size() > 0) begin
                e = q.pop_front();
                inv = ~e.gnt;
                chk("gnt", int'(gnt), int'(e.gnt));
                chk("oe_n", int'(oe_n), int'(inv));
                chk("busy", int'(busy), int'(e.busy));
                chk("owner", int'(owner), int'(e.owner));
            end
        end
    end

    initial begin : stimulus
        logic [N-1:0] v;
        rst = 1'b0;
        req = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b1;
        drive('0);

        // Single requester for three cycles, then idle.
        cycle(4'b0100, 3);
        cycle(4'b0000, 4);

        // Reset mid-grant, then everyone requests: requester 0 first.
        cycle(4'b0100, 3);
        do_reset();
        cycle(4'b1111, 40);
        cycle(4'b0000, 3);

        // Simultaneous arrival of requesters 0 and 3.
        do_reset();
        cycle(4'b1001, 4);
        cycle(4'b1000, 6);
        cycle(4'b0000, 3);

        // Long holder with a waiting requester.
        do_reset();
        cycle(4'b1010, 20);
        cycle(4'b1000, 6);
        cycle(4'b0000, 3);

        // Sole requester keeps requesting: regranted after turnaround.
        cycle(4'b0010, 12);
        cycle(4'b0000, 3);

        // Random level requests that flip occasionally.
        v = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(7) == 0) v[b] = ~v[b];
            if (i == 1500) begin
                do_reset();
            end else begin
                cycle(v, 1);
            end
        end
        cycle(4'b0000, 4);

        repeat (3) @(posedge clk);
        #2;
        chk("sb_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
